// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
// Shared definitions for the memory bus arbiter:
//   - arb_state_t      : arbiter FSM state encoding
//   - BSEL_BUS_W       : byte-select width of the default 32-bit bus
//   - WAIT_MAX_DEFAULT : default access timeout, in cycles
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } arb_state_t;

  localparam int BSEL_BUS_W       = 4;
  localparam int WAIT_MAX_DEFAULT = 15;

endpackage

// File: rtl/mem_bus_timer.sv
// mem_bus_timer
// Access timeout counter. It is held at zero while clear is high. Otherwise
// it counts up while inc is high and stops at WAIT_MAX, where expired is
// asserted.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   clear   in   force the count to zero
//   inc     in   advance the count by one
//   expired out  count has reached WAIT_MAX
module mem_bus_timer #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = $clog2(WAIT_MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(WAIT_MAX));

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Lets instruction fetch and the mem_stage data port share one external
// memory bus. Data requests have priority over instruction requests. The
// block raises stall requests until each access is satisfied. When the
// owning stage is held at completion, the result is kept in a buffer until
// that stage advances. A timeout forces completion of any access that is
// never acknowledged.
// Ports:
//   cpu_clk_50M, cpu_rst_n   clock and synchronous active-low reset
//   ice, iaddr               instruction fetch request and address
//   inst_o, stallreq_if      fetched word and fetch stall request
//   if_stall                 IF stage held this cycle
//   dce, daddr, we, din      data request, address, byte write enables, store data
//   dm_o, stallreq_mem       load word and data stall request
//   mem_stall                MEM stage held this cycle
//   flush                    exception flush
//   bus_req/wr/addr/be/wdata outgoing bus access (registered)
//   bus_ack, bus_rdata       bus completion and read data
//   bus_err                  one-cycle pulse when an access times out
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = BSEL_BUS_W * 8,
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic                  cpu_clk_50M,
  input  logic                  cpu_rst_n,
  input  logic                  ice,
  input  logic [ADDR_W-1:0]     iaddr,
  output logic [DATA_W-1:0]     inst_o,
  output logic                  stallreq_if,
  input  logic                  if_stall,
  input  logic                  dce,
  input  logic [ADDR_W-1:0]     daddr,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dm_o,
  output logic                  stallreq_mem,
  input  logic                  mem_stall,
  input  logic                  flush,
  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W/8-1:0]   bus_be,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic                  bus_err
);

  arb_state_t        state;
  logic [DATA_W-1:0] d_buf, i_buf;
  logic              d_buf_valid, i_buf_valid;
  logic              drop_d, drop_i;
  logic              in_acc, expired, timeout, done, d_done, i_done;
  logic [DATA_W-1:0] rdata_eff;

  assign in_acc = (state != IDLE);

  // The counter stays at zero in IDLE, so every access starts counting from
  // zero. A timeout fires in the cycle where the count equals WAIT_MAX.
  mem_bus_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk     (cpu_clk_50M),
    .rst_n   (cpu_rst_n),
    .clear   (!in_acc),
    .inc     (in_acc),
    .expired (expired)
  );

  // A real ack wins over a timeout that lands in the same cycle. A timed-out
  // access completes like an ack, but its read data is forced to zero.
  assign timeout   = in_acc && expired && !bus_ack;
  assign done      = in_acc && (bus_ack || expired);
  assign d_done    = (state == D_ACC) && done;
  assign i_done    = (state == I_ACC) && done;
  assign rdata_eff = timeout ? '0 : bus_rdata;
  assign bus_err   = timeout;

  assign stallreq_mem = dce && !d_buf_valid && !d_done;
  assign stallreq_if  = ice && !i_buf_valid && !i_done;
  assign dm_o         = d_buf_valid ? d_buf : rdata_eff;
  assign inst_o       = i_buf_valid ? i_buf : rdata_eff;

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state       <= IDLE;
      bus_req     <= 1'b0;
      bus_wr      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      d_buf       <= '0;
      i_buf       <= '0;
      d_buf_valid <= 1'b0;
      i_buf_valid <= 1'b0;
      drop_d      <= 1'b0;
      drop_i      <= 1'b0;
    end else begin
      // A buffered result is consumed on the first cycle its stage advances.
      // A flush discards it.
      if (flush || !mem_stall) d_buf_valid <= 1'b0;
      if (flush || !if_stall)  i_buf_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (dce && !d_buf_valid && !flush) begin
            state     <= D_ACC;
            bus_req   <= 1'b1;
            bus_wr    <= |we;
            bus_addr  <= daddr;
            bus_be    <= (|we) ? we : '1;
            bus_wdata <= din;
          end else if (ice && !i_buf_valid && !flush) begin
            state     <= I_ACC;
            bus_req   <= 1'b1;
            bus_wr    <= 1'b0;
            bus_addr  <= iaddr;
            bus_be    <= '1;
            bus_wdata <= '0;
          end
        end

        // An access that is flushed still runs to completion on the bus,
        // so a store is never left half-issued. Its result is then dropped.
        D_ACC: begin
          if (done) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            bus_wr  <= 1'b0;
            drop_d  <= 1'b0;
            // A completed store also marks the buffer valid, so the held
            // stage does not issue the store a second time.
            if (!drop_d && !flush && mem_stall) begin
              d_buf_valid <= 1'b1;
              if (!bus_wr) d_buf <= rdata_eff;
            end
          end else if (flush) begin
            drop_d <= 1'b1;
          end
        end

        I_ACC: begin
          if (done) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            drop_i  <= 1'b0;
            if (!drop_i && !flush && if_stall) begin
              i_buf_valid <= 1'b1;
              i_buf       <= rdata_eff;
            end
          end else if (flush) begin
            drop_i <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
          bus_wr  <= 1'b0;
        end
      endcase
    end
  end

endmodule
